// File: rtl/bitstream_pwm_regen.sv
// bitstream_pwm_regen: turns a 1-bit digitizer bitstream into a proportional PWM.
// Ones are counted over 2^WIN_W enabled samples, centred, optionally DC-corrected,
// scaled and clamped into a PWM_W-bit duty word that drives a glitch-free PWM.
// Optional feature: define BITSTREAM_PWM_DC_REMOVE_EN to include the first-order
// IIR DC estimator; without it the centred window count is used directly.
module bitstream_pwm_regen #(
    parameter int WIN_W    = 8,
    parameter int PWM_W    = 8,
    parameter int DC_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             en,
    output logic [PWM_W-1:0] duty_out,
    output logic             win_valid,
    output logic             sat,
    output logic             pwm_out
);

    // Working width for centred and DC-corrected values: holds +-2^WIN_W without wrap.
    localparam int CW = WIN_W + 2;

    localparam logic [WIN_W-1:0]       WCNT_LAST = '1;
    localparam logic [WIN_W-1:0]       WCNT_ONE  = WIN_W'(1);
    localparam logic [PWM_W-1:0]       PCNT_LAST = '1;
    localparam logic [PWM_W-1:0]       PCNT_ONE  = PWM_W'(1);
    localparam logic [PWM_W-1:0]       DUTY_MID  = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic signed [CW-1:0]   HALF_WIN  = CW'(2 ** (WIN_W - 1));
    localparam logic signed [CW-1:0]   S_MAX     = CW'(2 ** (PWM_W - 1) - 1);
    localparam logic signed [CW-1:0]   S_MIN     = CW'(-(2 ** (PWM_W - 1)));

    logic [WIN_W-1:0]       wcnt;
    logic [WIN_W:0]         acc;
    logic [WIN_W:0]         acc_next;
    logic [WIN_W:0]         win_sum;
    logic                   win_close;
    logic signed [CW-1:0]   c;
    logic signed [CW-1:0]   dc_est;
    logic signed [CW-1:0]   ac;
    logic signed [CW-1:0]   s;
    logic signed [CW-1:0]   s_clamped;
    logic                   clamp;
    logic [PWM_W-1:0]       duty_next;
    logic [PWM_W-1:0]       pcnt;
    logic [PWM_W-1:0]       duty_act;

    assign acc_next = acc + {{WIN_W{1'b0}}, sig};

    // Window counter and ones accumulator; win_close flags edge E for the scaling stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            acc       <= '0;
            win_sum   <= '0;
            win_close <= 1'b0;
        end else begin
            win_close <= 1'b0;
            if (en) begin
                wcnt <= wcnt + WCNT_ONE;
                if (wcnt == WCNT_LAST) begin
                    win_sum   <= acc_next;
                    acc       <= '0;
                    win_close <= 1'b1;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

    assign c = $signed({1'b0, win_sum}) - HALF_WIN;

`ifdef BITSTREAM_PWM_DC_REMOVE_EN
    localparam int DW = WIN_W + 1 + DC_SHIFT;

    logic signed [DW-1:0] dc_acc;
    logic signed [DW-1:0] dc_shifted;

    assign dc_shifted = dc_acc >>> DC_SHIFT;
    assign dc_est     = CW'(dc_shifted);

    // IIR DC estimator integrates the corrected value once per window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_acc <= '0;
        end else if (win_close) begin
            dc_acc <= dc_acc + DW'(ac);
        end
    end
`else
    assign dc_est = '0;
`endif

    assign ac = c - dc_est;
    assign s  = ac >>> (WIN_W - PWM_W);

    // Clamp the scaled value into the signed duty range and flag saturation.
    always_comb begin
        s_clamped = s;
        clamp     = 1'b0;
        if (s > S_MAX) begin
            s_clamped = S_MAX;
            clamp     = 1'b1;
        end else if (s < S_MIN) begin
            s_clamped = S_MIN;
            clamp     = 1'b1;
        end
    end

    // Adding midscale to an in-range two's complement value is an MSB flip.
    assign duty_next = PWM_W'(s_clamped) ^ DUTY_MID;

    // Edge E+1: publish the new duty word and saturation flag, independent of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_out  <= DUTY_MID;
            sat       <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= win_close;
            if (win_close) begin
                duty_out <= duty_next;
                sat      <= clamp;
            end
        end
    end

    // Free-running PWM; duty is only reloaded at the period wrap so no period is split.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt     <= '0;
            duty_act <= DUTY_MID;
            pwm_out  <= 1'b0;
        end else begin
            pcnt    <= pcnt + PCNT_ONE;
            pwm_out <= (pcnt < duty_act);
            if (pcnt == PCNT_LAST) begin
                duty_act <= duty_out;
            end
        end
    end

endmodule

// File: doc/bitstream_pwm_regen.md
# bitstream_pwm_regen

- Regenerates an analog-proportional PWM from the 1-bit comparator/LVDS bitstream delivered by the digitizer.
- Counts ones over a parametrised window of 2^WIN_W enabled samples and centres the count around zero.
- Optionally removes the DC component with a first-order IIR estimator.
- Scales and clamps the result into a PWM_W-bit duty word driving a glitch-free PWM; sits between the digitizer and the `pwm_out` pin.

## Interface
- WIN_W, 8: log2 of window length in enabled samples.
- PWM_W, 8: PWM resolution in bits; must satisfy PWM_W <= WIN_W.
- DC_SHIFT, 4: IIR time constant, 2^DC_SHIFT windows.
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- sig  in  1  bitstream sample, already synchronous to clk.
- en  in  1  sample enable; when low, the window logic holds.
- duty_out  out  PWM_W  current duty word, unsigned, midscale = zero signal.
- win_valid  out  1  one-cycle pulse when duty_out updates.
- sat  out  1  duty_out was clamped in the last window; updated with duty_out.
- pwm_out  out  1  registered PWM output.

## Operation
**Window**
- wcnt (WIN_W bits) and acc (WIN_W+1 bits) advance only when en=1.
- Each enabled cycle: acc += sig.
- On the enabled cycle with wcnt = 2^WIN_W-1:
  - win_sum <= acc + sig;
  - acc <= 0;
  - wcnt wraps to 0.
- The window contains exactly 2^WIN_W samples; cycles with en=0 are not counted.

**Centring**
- c = win_sum - 2^(WIN_W-1), signed, WIN_W+1 bits.
- Range of c: -2^(WIN_W-1)..+2^(WIN_W-1).

**DC estimator**
- dc_acc: signed, WIN_W+1+DC_SHIFT bits.
- dc_est = dc_acc >>> DC_SHIFT.
- Once per window: ac = c - dc_est, using the old dc_est (WIN_W+2 bits signed).
- Same update: dc_acc <= dc_acc + c - dc_est.

**Scaling**
- s = ac >>> (WIN_W - PWM_W).
- Clamp s to [-2^(PWM_W-1), 2^(PWM_W-1)-1]; sat = 1 if the clamp engaged, else 0.
- duty_out = s + 2^(PWM_W-1), unsigned.

**PWM**
- pcnt (PWM_W bits) free-runs every cycle, independent of en.
- duty_act loads duty_out only on the cycle pcnt = 2^PWM_W-1, so a period is never split.
- pwm_out <= (pcnt < duty_act).
- Duty 0 gives a constant low; the maximum duty gives high for 2^PWM_W-1 of 2^PWM_W cycles.

## Timing
**Reset values (rst high, asynchronous)**
- wcnt, acc, win_sum, dc_acc, pcnt: 0.
- duty_out = duty_act = 2^(PWM_W-1).
- win_valid = 0, sat = 0, pwm_out = 0.

**Latency**
- Edge E: latches win_sum (last sample's clock edge).
- Edge E+1: registers duty_out, sat and dc_acc, and asserts win_valid for exactly one cycle.
- Total latency from last sample to new duty_out: 2 cycles.
- duty_out reaches pwm_out at the next PWM period boundary: up to 2^PWM_W cycles after win_valid, plus 1.

**Boundary conditions**
- en low on the last-sample cycle: the window does not close until the next enabled cycle.
- en low while a result is in the pipeline: the pipeline still completes; E+1 is not gated by en.
- Window close coinciding with a PWM wrap: duty_act takes the previous duty_out; the new value applies one period later.
- Mid-operation rst: all state returns to reset values immediately; the partial window is discarded.
- Arithmetic: no wrap-around anywhere; widths above are sufficient for full-scale c of either sign.

## Configuration
- Macro: `BITSTREAM_PWM_DC_REMOVE_EN`.
- Defined: DC estimator present as described.
- Undefined:
  - dc_acc is not instantiated;
  - dc_est = 0 and ac = c;
  - all other behaviour and timing are unchanged.

## Test plan
All tests use WIN_W=8, PWM_W=8, DC_SHIFT=4.

- Reset check: assert rst for 3 cycles, then release -> during rst duty_out=0x80, win_valid=0, sat=0, pwm_out=0; after release pwm_out high 128 of every 256 cycles.
- Full-scale high, macro undefined: sig=1, en=1 -> c=+128, clamped; duty_out=0xFF, sat=1, win_valid 2 cycles after the 256th sample; pwm_out high 255/256.
- Full-scale low, macro undefined: sig=0 -> c=-128; duty_out=0x00, sat=0; pwm_out constantly low after the next period boundary.
- DC removal, macro defined: sig pattern 1,1,1,0 repeated -> c=+64 every window:
  - window 1: duty_out=0xC0;
  - window 2: duty_out=0xBC (dc_est=4);
  - converges monotonically to 0x80..0x81 within 150 windows; sat=0 throughout.
- Enable gating: sig=1, en toggled 1/0 every cycle -> window closes after 512 clocks; same duty_out=0xFF as the continuous case; PWM period stays 256 clocks.
- Reset mid-window: rst pulsed 1 cycle at sample 100 -> outputs return to reset values asynchronously; next win_valid 256+2 enabled cycles after release.
